// File: rtl/mulf_seq_reg.sv
// Multifunction register: load, increment/decrement, and bit-serial shift/rotate
// driven by a two-state sequencer that reports busy/done and the outgoing bit.
module mulf_seq_reg #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [SHW-1:0]   amt,
  input  logic             sin,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             cout,
  output logic             zero
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_ROL  = 3'b110,
    OP_ROR  = 3'b111
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   inc_sum;
  logic [WIDTH-1:0] dec_val;
  logic             dec_borrow;
  logic [WIDTH-1:0] step_val;
  logic             step_bit;

  assign inc_sum    = {1'b0, q_q} + (WIDTH + 1)'(1);
  assign dec_val    = q_q - WIDTH'(1);
  assign dec_borrow = (q_q == '0);

  // One step of the latched shift/rotate and the bit that leaves the register
  always_comb begin
    step_val = q_q;
    step_bit = 1'b0;
    case (op_q)
      OP_SHL: begin
        step_val = {q_q[WIDTH-2:0], sin};
        step_bit = q_q[WIDTH-1];
      end
      OP_SHR: begin
        step_val = {sin, q_q[WIDTH-1:1]};
        step_bit = q_q[0];
      end
      OP_ROL: begin
        step_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        step_bit = q_q[WIDTH-1];
      end
      OP_ROR: begin
        step_val = {q_q[0], q_q[WIDTH-1:1]};
        step_bit = q_q[0];
      end
      default: begin
        step_val = q_q;
        step_bit = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op_e'(op))
            OP_HOLD: begin
              cout_d = 1'b0;
              done_d = 1'b1;
            end
            OP_LOAD: begin
              q_d    = din;
              cout_d = 1'b0;
              done_d = 1'b1;
            end
            OP_INC: begin
              q_d    = inc_sum[WIDTH-1:0];
              cout_d = inc_sum[WIDTH];
              done_d = 1'b1;
            end
            OP_DEC: begin
              q_d    = dec_val;
              cout_d = dec_borrow;
              done_d = 1'b1;
            end
            default: begin
              // A zero-length shift completes immediately and leaves cout alone
              if (amt == '0) begin
                done_d = 1'b1;
              end else begin
                op_d    = op_e'(op);
                cnt_d   = amt;
                state_d = SHIFT;
              end
            end
          endcase
        end
      end
      SHIFT: begin
        q_d    = step_val;
        cout_d = step_bit;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD;
      cnt_q   <= '0;
      q_q     <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign cout = cout_q;
  assign zero = (q_q == '0);

endmodule

// File: tb/tb_mulf_seq_reg.sv
// Bench for mulf_seq_reg: directed scenarios then random commands, all checked
// cycle by cycle against an arithmetic model of the register.
module tb_mulf_seq_reg;

  localparam int W    = 8;
  localparam int SHW  = 3;
  localparam int MOD  = 256;
  localparam int HALF = 128;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [2:0]     op;
  logic [SHW-1:0] amt;
  logic           sin;
  logic [W-1:0]   din;
  logic [W-1:0]   q;
  logic           busy;
  logic           done;
  logic           cout;
  logic           zero;

  int checks = 0;
  int errors = 0;

  int m_q, m_cout, m_done, m_busy, m_left, m_op;

  mulf_seq_reg #(.WIDTH(W), .SHW(SHW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .amt   (amt),
    .sin   (sin),
    .din   (din),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .cout  (cout),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_cout = 0; m_done = 0; m_busy = 0; m_left = 0; m_op = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    int s;
    s = int'(sin);
    if (m_busy == 0) begin
      m_done = 0;
      if (start) begin
        case (int'(op))
          0: begin m_cout = 0; m_done = 1; end
          1: begin m_q = int'(din); m_cout = 0; m_done = 1; end
          2: begin m_cout = (m_q == MOD - 1); m_q = (m_q + 1) % MOD; m_done = 1; end
          3: begin m_cout = (m_q == 0); m_q = (m_q + MOD - 1) % MOD; m_done = 1; end
          default: begin
            if (amt == 0) m_done = 1;
            else begin m_busy = 1; m_left = int'(amt); m_op = int'(op); end
          end
        endcase
      end
    end else begin
      case (m_op)
        4: begin m_cout = m_q / HALF; m_q = (m_q * 2 + s) % MOD; end
        5: begin m_cout = m_q % 2; m_q = m_q / 2 + s * HALF; end
        6: begin m_cout = m_q / HALF; m_q = (m_q * 2) % MOD + m_cout; end
        default: begin m_cout = m_q % 2; m_q = m_q / 2 + m_cout * HALF; end
      endcase
      m_left--;
      m_done = 0;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic check_output();
    chk("q", q, m_q);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("cout", cout, m_cout);
    chk("zero", zero, (m_q == 0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_output();
  endtask

  // Asynchronous reset strictly between clock edges
  task automatic reset_pulse();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_output();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [2:0] o, input logic [SHW-1:0] a,
                                input logic [W-1:0] d, input logic s);
    start = 1'b1; op = o; amt = a; din = d; sin = s;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && m_busy != 0; i++) tick();
    chk("wait_idle_busy", busy, 1'b0);
    tick();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = '0; amt = '0; sin = 1'b0; din = '0;
    model_reset();
    #1;
    check_output();
    @(negedge clk);
    reset = 1'b1;
    tick();

    apply_stimulus(3'b001, 3'd0, 8'h3C, 1'b0);
    apply_stimulus(3'b010, 3'd0, 8'h00, 1'b0);
    reset_pulse();
    chk("mid_reset_q", q, 8'h00);
    chk("mid_reset_zero", zero, 1'b1);
    tick();

    apply_stimulus(3'b001, 3'd0, 8'hFE, 1'b0);
    apply_stimulus(3'b010, 3'd0, 8'h00, 1'b0);
    chk("inc1_q", q, 8'hFF);
    chk("inc1_cout", cout, 1'b0);
    apply_stimulus(3'b010, 3'd0, 8'h00, 1'b0);
    chk("inc2_q", q, 8'h00);
    chk("inc2_cout", cout, 1'b1);
    apply_stimulus(3'b011, 3'd0, 8'h00, 1'b0);
    chk("dec_q", q, 8'hFF);
    chk("dec_cout", cout, 1'b1);
    tick();

    apply_stimulus(3'b001, 3'd0, 8'h81, 1'b0);
    apply_stimulus(3'b110, 3'd3, 8'h00, 1'b0);
    wait_idle();
    chk("rol_q", q, 8'h0C);
    chk("rol_cout", cout, 1'b0);

    apply_stimulus(3'b001, 3'd0, 8'h0F, 1'b1);
    apply_stimulus(3'b101, 3'd2, 8'h00, 1'b1);
    start = 1'b1; op = 3'b001; din = 8'h55;
    tick();
    tick();
    start = 1'b0;
    tick();
    chk("shr_q", q, 8'hC3);
    chk("shr_cout", cout, 1'b1);

    apply_stimulus(3'b001, 3'd0, 8'hA5, 1'b0);
    apply_stimulus(3'b100, 3'd0, 8'h00, 1'b1);
    chk("shl0_done", done, 1'b1);
    chk("shl0_busy", busy, 1'b0);
    chk("shl0_q", q, 8'hA5);
    tick();
    apply_stimulus(3'b001, 3'd0, 8'h01, 1'b0);
    apply_stimulus(3'b100, 3'd7, 8'h00, 1'b0);
    wait_idle();
    chk("shl7_q", q, 8'h80);

    apply_stimulus(3'b001, 3'd0, 8'h96, 1'b0);
    apply_stimulus(3'b111, 3'd5, 8'h00, 1'b0);
    tick();
    tick();
    reset_pulse();
    chk("ror_abort_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) tick();

    for (int n = 0; n < 600; n++) begin
      start = 1'($urandom_range(0, 1));
      op    = 3'($urandom_range(0, 7));
      amt   = SHW'($urandom_range(0, 7));
      sin   = 1'($urandom_range(0, 1));
      din   = W'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) reset_pulse();
      else tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
